message_sequencer: RTL and testbench
====================================

MESSAGE_SEQUENCER -- requirements
Module: message_sequencer

Interface
REQ-001 Parameter DWELL, default 4: clock cycles each character is held after acceptance; legal range 1..255.
REQ-002 Parameter MSG_W, default 2: width of the message-select bus.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request to play the message on msg_sel.
REQ-006 msg_sel  in  MSG_W  message to play; sampled only when a start is accepted.
REQ-007 msg_id  out  MSG_W  latched select driving the message-ROM mux.
REQ-008 len_string  in  4  message length in characters, from the selected ROM.
REQ-009 caracter  in  4  character code from the selected ROM at counter_caracter.
REQ-010 counter_caracter  out  4  character index presented to the ROM.
REQ-011 char_out  out  4  registered character code sent to the display driver.
REQ-012 char_valid  out  1  char_out is valid and is waiting for the display driver.
REQ-013 char_ready  in  1  display-driver acceptance of char_out.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse when a message completes.

Function
REQ-016 States: IDLE, LOAD, FETCH, PRESENT, DWELL, DONE; the encoding comes from the shared package.
REQ-017 IDLE: start=1 -> latch msg_id<=msg_sel, go to LOAD; start=0 -> stay in IDLE.
REQ-018 start is ignored while busy=1, and msg_sel changes while busy=1 do not affect msg_id.
REQ-019 LOAD: capture len_string into len_q, set counter_caracter=0; len_q=0 -> DONE, otherwise -> FETCH.
REQ-020 FETCH, one cycle: char_out<=caracter -> PRESENT.
REQ-021 PRESENT: char_valid=1; stay while char_ready=0; on char_ready=1 load the dwell timer with DWELL-1 -> DWELL.
REQ-022 char_out is stable for the whole of PRESENT; char_ready outside PRESENT has no effect.
REQ-023 DWELL: decrement the timer each cycle; at timer=0 and counter_caracter=len_q-1 -> DONE.
REQ-024 DWELL: at timer=0 and counter_caracter<len_q-1 -> counter_caracter+1, go to FETCH.
REQ-025 DONE: done=1 for exactly one cycle -> IDLE; counter_caracter holds its last value.
REQ-026 Cycles per character = 1 + (PRESENT wait, at least 1) + DWELL.
REQ-027 Index arithmetic is 4-bit unsigned with no wrap; the maximum length is 15.
REQ-028 len_string changing after LOAD has no effect.
REQ-029 char_valid and done are never high in the same cycle.

Reset
REQ-030 On reset, independent of clk: state=IDLE, msg_id=0, counter_caracter=0, char_out=0, char_valid=0, busy=0, done=0, timer=0, len_q=0.
REQ-031 Reset asserted mid-message aborts the message with no done pulse; after release the block waits in IDLE for a new start.

Configuration
REQ-032 Macro MESSAGE_SEQUENCER_LOOP_EN controls loop mode.
REQ-033 With MESSAGE_SEQUENCER_LOOP_EN defined, input port stop (1 bit) exists.
REQ-034 In loop mode, DWELL expiry on the last character returns to counter_caracter=0 and FETCH, with no done pulse.
REQ-035 In loop mode, a stop sampled high while busy=1 is registered; the block goes to DONE at the next character boundary, emitting done and returning to IDLE.
REQ-036 Without the macro, the stop port does not exist and the block plays a single pass as described under Function.

Structure
REQ-037 Shared package holds the state encoding, the 4-bit character-code constants (A=0, D=2, E=3, I=4, J=5, O=7, R=9, T=10) and the message-ID constants.
REQ-038 The dwell counter is a sub-module, dwell_timer, with ports load, value, tick and expired.

Verification
REQ-039 DWELL=4, msg_sel=1, len 8, ROM codes 9,3,5,3,4,10,0,2, char_ready tied high -> char_out shows that sequence, each character 6 cycles apart, then one done pulse.
REQ-040 len_string=0 with start -> no char_valid; done is high exactly 2 cycles after start.
REQ-041 char_ready held low for 10 cycles on character 3 -> char_valid and char_out=3 stay stable; the sequence resumes after acceptance.
REQ-042 start with msg_sel=2 is pulsed again mid-message -> msg_id stays 1 and no restart occurs.
REQ-043 reset asserted during the DWELL of character 5 -> all outputs 0 immediately, no done; a later start plays from index 0.
REQ-044 Loop build: len 3, stop pulsed during the second pass -> the pass finishes its current character, done is pulsed once, then IDLE.

Source files
------------

// File: rtl/message_sequencer_pkg.sv
// Shared definitions for the message sequencer: FSM state encoding,
// 4-bit character codes and message-ID constants.
package message_sequencer_pkg;

    localparam int CHAR_W  = 4;
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_PRESENT,
        ST_DWELL,
        ST_DONE
    } state_e;

    localparam logic [CHAR_W-1:0] CH_A = 4'd0;
    localparam logic [CHAR_W-1:0] CH_D = 4'd2;
    localparam logic [CHAR_W-1:0] CH_E = 4'd3;
    localparam logic [CHAR_W-1:0] CH_I = 4'd4;
    localparam logic [CHAR_W-1:0] CH_J = 4'd5;
    localparam logic [CHAR_W-1:0] CH_O = 4'd7;
    localparam logic [CHAR_W-1:0] CH_R = 4'd9;
    localparam logic [CHAR_W-1:0] CH_T = 4'd10;

    localparam int MSG_ID_BLANK  = 0;
    localparam int MSG_ID_REJECT = 1;
    localparam int MSG_ID_ALT    = 2;
    localparam int MSG_ID_AUX    = 3;

endpackage

// File: rtl/message_sequencer_dwell_timer.sv
// Down-counting hold timer: loads a value, decrements on tick, and
// reports expiry when the count has reached zero.
module dwell_timer
    import message_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    input  logic               tick,
    output logic               expired
);

    logic [TIMER_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (tick && count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/message_sequencer.sv
// Plays a ROM message one character at a time with a ready handshake and a
// fixed dwell per character. Define MESSAGE_SEQUENCER_LOOP_EN for loop mode.
module message_sequencer
    import message_sequencer_pkg::*;
#(
    parameter int unsigned DWELL = 4,
    parameter int unsigned MSG_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MSG_W-1:0]  msg_sel,
    output logic [MSG_W-1:0]  msg_id,
    input  logic [CHAR_W-1:0] len_string,
    input  logic [CHAR_W-1:0] caracter,
    output logic [CHAR_W-1:0] counter_caracter,
    output logic [CHAR_W-1:0] char_out,
    output logic              char_valid,
    input  logic              char_ready,
`ifdef MESSAGE_SEQUENCER_LOOP_EN
    input  logic              stop,
`endif
    output logic              busy,
    output logic              done
);

    localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL - 1);

    state_e             state_q, state_d;
    logic [MSG_W-1:0]   msg_id_q, msg_id_d;
    logic [CHAR_W-1:0]  len_q, len_d;
    logic [CHAR_W-1:0]  cnt_q, cnt_d;
    logic [CHAR_W-1:0]  char_q, char_d;
    logic               timer_load, timer_tick, timer_expired;
    logic               last_char;
    logic               stop_now;

`ifdef MESSAGE_SEQUENCER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
    logic stop_q, stop_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stop_q <= 1'b0;
        else       stop_q <= stop_d;
    end

    assign stop_now = stop_q;
`else
    localparam bit LOOP_EN = 1'b0;
    assign stop_now = 1'b0;
`endif

    dwell_timer u_dwell_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .value   (DWELL_LOAD),
        .tick    (timer_tick),
        .expired (timer_expired)
    );

    assign last_char = (cnt_q == len_q - 4'd1);

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        msg_id_d   = msg_id_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        char_d     = char_q;
        timer_load = 1'b0;
        timer_tick = 1'b0;
`ifdef MESSAGE_SEQUENCER_LOOP_EN
        stop_d = stop_q | (stop & (state_q != ST_IDLE));
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    msg_id_d = msg_sel;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                len_d   = len_string;
                cnt_d   = '0;
                state_d = (len_string == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                char_d  = caracter;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (char_ready) begin
                    timer_load = 1'b1;
                    state_d    = ST_DWELL;
                end
            end
            ST_DWELL: begin
                timer_tick = 1'b1;
                // Character boundary: finish, wrap to the first char, or advance.
                if (timer_expired) begin
                    if (stop_now || (last_char && !LOOP_EN)) begin
                        state_d = ST_DONE;
                    end else if (last_char) begin
                        cnt_d   = '0;
                        state_d = ST_FETCH;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef MESSAGE_SEQUENCER_LOOP_EN
                stop_d = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            msg_id_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            char_q   <= '0;
        end else begin
            state_q  <= state_d;
            msg_id_q <= msg_id_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            char_q   <= char_d;
        end
    end

    assign msg_id           = msg_id_q;
    assign counter_caracter = cnt_q;
    assign char_out         = char_q;
    assign char_valid       = (state_q == ST_PRESENT);
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);

endmodule

// File: tb/tb_message_sequencer.sv
// Directed self-checking bench for message_sequencer (DWELL=4, MSG_W=2),
// with a small behavioural message ROM driven from counter_caracter.
module tb_message_sequencer;
    import message_sequencer_pkg::*;

    logic       clk, reset, start, char_ready;
    logic [1:0] msg_sel, msg_id;
    logic [3:0] len_string, caracter, counter_caracter, char_out;
    logic       char_valid, busy, done;
`ifdef MESSAGE_SEQUENCER_LOOP_EN
    logic       stop_in;
    int         stop_k;
`endif

    message_sequencer #(.DWELL(4), .MSG_W(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .msg_sel          (msg_sel),
        .msg_id           (msg_id),
        .len_string       (len_string),
        .caracter         (caracter),
        .counter_caracter (counter_caracter),
        .char_out         (char_out),
        .char_valid       (char_valid),
        .char_ready       (char_ready),
`ifdef MESSAGE_SEQUENCER_LOOP_EN
        .stop             (stop_in),
`endif
        .busy             (busy),
        .done             (done)
    );

    logic [3:0] rom [16];
    logic [3:0] exp_v [8];
    assign caracter = (msg_id == 2'd1) ? rom[counter_caracter] : 4'hF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] got_v [$];
    int         got_k [$];
    int         done_cnt, done_k, overlap, stable_cnt, valid_cnt;
    logic       last_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Starts a message and runs cycle by cycle (sampling on negedge), with
    // optional stall on one index, a start poke, and a mid-message reset.
    task automatic play(input int len, input int stall_idx, input int poke_k,
                        input int reset_k, input int budget);
        int stall_left;
        stall_left = 10;
        got_v.delete();
        got_k.delete();
        done_cnt = 0; done_k = -1; overlap = 0; stable_cnt = 0; valid_cnt = 0;
        len_string = 4'(len);
        msg_sel    = 2'd1;
        char_ready = 1'b1;
        start      = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) len_string = 4'd3;
            if (char_valid && done) overlap++;
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (char_valid) begin
                valid_cnt++;
                if (int'(counter_caracter) == stall_idx && char_out == 4'd3) stable_cnt++;
                if (int'(counter_caracter) == stall_idx && stall_left > 0) begin
                    char_ready = 1'b0;
                    stall_left--;
                end else begin
                    char_ready = 1'b1;
                    got_v.push_back(char_out);
                    got_k.push_back(k);
                end
            end else begin
                char_ready = 1'b1;
            end
            if (k == poke_k) begin
                start   = 1'b1;
                msg_sel = 2'd2;
            end
            if (k == poke_k + 1) start = 1'b0;
`ifdef MESSAGE_SEQUENCER_LOOP_EN
            if (k == stop_k) stop_in = 1'b1;
            if (k == stop_k + 1) stop_in = 1'b0;
`endif
            if (k == reset_k) begin
                check("rst_at_char5", {28'd0, counter_caracter}, 32'd5);
                reset = 1'b1;
                #1;
                check("rst_async_zero",
                      {19'd0, msg_id, counter_caracter, char_out, char_valid, busy, done},
                      32'd0);
            end
            if (k == reset_k + 1) reset = 1'b0;
            last_busy = busy;
            if (done_k > 0 && k > done_k) break;
        end
    endtask

    // Full 8-character pass; shift is the extra delay from index 3 onward.
    task automatic verify_pass(input string tag, input int shift);
        check({tag, "_count"}, got_v.size(), 32'd8);
        for (int i = 0; i < 8 && i < got_v.size(); i++) begin
            check($sformatf("%s_char%0d", tag, i), {28'd0, got_v[i]}, {28'd0, exp_v[i]});
            check($sformatf("%s_time%0d", tag, i), got_k[i], 3 + 6 * i + ((i >= 3) ? shift : 0));
        end
        check({tag, "_done_k"}, done_k, 50 + shift);
        check({tag, "_done_cnt"}, done_cnt, 32'd1);
        check({tag, "_overlap"}, overlap, 32'd0);
        check({tag, "_idle_busy"}, {31'd0, last_busy}, 32'd0);
        check({tag, "_msg_id"}, {30'd0, msg_id}, 32'd1);
        check({tag, "_idx_hold"}, {28'd0, counter_caracter}, 32'd7);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'hE;
        exp_v = '{CH_R, CH_E, CH_J, CH_E, CH_I, CH_T, CH_A, CH_D};
        for (int i = 0; i < 8; i++) rom[i] = exp_v[i];

        reset = 1'b1; start = 1'b0; msg_sel = 2'd0; len_string = 4'd0; char_ready = 1'b0;
`ifdef MESSAGE_SEQUENCER_LOOP_EN
        stop_in = 1'b0;
        stop_k  = -1;
`endif
        repeat (2) @(negedge clk);
        check("reset_state",
              {19'd0, msg_id, counter_caracter, char_out, char_valid, busy, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {31'd0, busy}, 32'd0);

`ifndef MESSAGE_SEQUENCER_LOOP_EN
        play(8, -1, -1, -1, 80);
        verify_pass("pass", 0);

        play(8, 3, 25, -1, 100);
        verify_pass("stall", 10);
        check("stall_stable_cycles", stable_cnt, 32'd11);
`endif

        play(0, -1, -1, -1, 20);
        check("empty_valid_cnt", valid_cnt, 32'd0);
        check("empty_done_k", done_k, 32'd2);
        check("empty_done_cnt", done_cnt, 32'd1);
        check("empty_idle_busy", {31'd0, last_busy}, 32'd0);

        play(8, -1, -1, 35, 45);
        check("rst_chars_before", got_v.size(), 32'd6);
        check("rst_no_done", done_cnt, 32'd0);
        check("rst_idle_busy", {31'd0, last_busy}, 32'd0);

`ifndef MESSAGE_SEQUENCER_LOOP_EN
        play(8, -1, -1, -1, 80);
        verify_pass("replay", 0);
`else
        stop_k = 23;
        play(3, -1, -1, -1, 60);
        check("loop_count", got_v.size(), 32'd4);
        for (int i = 0; i < 4 && i < got_v.size(); i++)
            check($sformatf("loop_char%0d", i), {28'd0, got_v[i]}, {28'd0, exp_v[i % 3]});
        check("loop_done_k", done_k, 32'd26);
        check("loop_done_cnt", done_cnt, 32'd1);
        check("loop_overlap", overlap, 32'd0);
        check("loop_idle_busy", {31'd0, last_busy}, 32'd0);
        stop_k = -1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
